// File: rtl/fc_layer_sequencer_pkg.sv
// Shared definitions for the fully-connected layer: sequencer states and
// the weight/bias ROM address map used by the sequencer, fc_neuron and ROM init.
package fc_pkg;

    typedef enum logic [2:0] {
        ACCUM = 3'd0,
        BIAS  = 3'd1,
        FLUSH = 3'd2,
        DONE  = 3'd3,
        CLEAR = 3'd4
    } fc_seq_state_t;

    // Addresses 0..H-1 are weights, address H is the bias.
    function automatic int fc_addr_width(input int h);
        return $clog2(h + 1);
    endfunction

    function automatic int fc_bias_addr(input int h);
        return h;
    endfunction

endpackage

// File: rtl/fc_layer_sequencer.sv
// Serial-input sequencer for one fully-connected layer: streams words, ROM
// addresses and sum/bias strobes to the neurons, then hands off the result.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    localparam int AW                   = fc_addr_width(PREVIOUS_LAYER_HEIGHT)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic signed [WORD_SIZE-1:0] data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic signed [WORD_SIZE-1:0] data_o,
    output logic [AW-1:0]               mem_addr_o,
    output logic                        sum_en_o,
    output logic                        add_bias_o,
    output logic                        neuron_clear_o,
    output logic                        valid_o,
    input  logic                        ready_i
);

    localparam logic [AW-1:0] LAST_CNT = AW'(PREVIOUS_LAYER_HEIGHT - 1);
    localparam logic [AW-1:0] BIAS_CNT = AW'(fc_bias_addr(PREVIOUS_LAYER_HEIGHT));

    fc_seq_state_t               state_q, state_d;
    logic [AW-1:0]               cnt_q, cnt_d;
    logic signed [WORD_SIZE-1:0] data_q, data_d;
    logic                        sum_en_q, sum_en_d;
    logic                        add_bias_q, add_bias_d;
    logic                        clear_q, clear_d;
    logic                        valid_q, valid_d;
    logic                        accept_s;

    assign accept_s = valid_i && (state_q == ACCUM);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (accept_s && (cnt_q == LAST_CNT)) begin
                    state_d = BIAS;
                end else begin
                    state_d = ACCUM;
                end
            end
            BIAS:  state_d = FLUSH;
            FLUSH: state_d = DONE;
            DONE: begin
                if (ready_i) begin
                    state_d = CLEAR;
                end else begin
                    state_d = DONE;
                end
            end
            CLEAR:   state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Output and datapath next-values; strobes land one cycle later so they
    // line up with the neurons' registered ROM read.
    always_comb begin
        ready_o    = (state_q == ACCUM);
        mem_addr_o = cnt_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        sum_en_d   = 1'b0;
        add_bias_d = 1'b0;
        clear_d    = 1'b0;
        valid_d    = 1'b0;
        case (state_q)
            ACCUM: begin
                if (accept_s) begin
                    data_d   = data_i;
                    sum_en_d = 1'b1;
                    cnt_d    = (cnt_q == LAST_CNT) ? BIAS_CNT : cnt_q + AW'(1);
                end else begin
                    sum_en_d = 1'b0;
                end
            end
            BIAS: begin
                sum_en_d   = 1'b1;
                add_bias_d = 1'b1;
            end
            FLUSH: valid_d = 1'b1;
            DONE: begin
                if (ready_i) begin
                    clear_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            CLEAR:   cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    // Counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            data_q     <= '0;
            sum_en_q   <= 1'b0;
            add_bias_q <= 1'b0;
            clear_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            sum_en_q   <= sum_en_d;
            add_bias_q <= add_bias_d;
            clear_q    <= clear_d;
            valid_q    <= valid_d;
        end
    end

    assign data_o         = data_q;
    assign sum_en_o       = sum_en_q;
    assign add_bias_o     = add_bias_q;
    assign neuron_clear_o = clear_q;
    assign valid_o        = valid_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer (H=4 and H=1) with a paired
// behavioural neuron and a timing-based reference model.
module tb_fc_layer_sequencer;

    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_i;
    logic signed [15:0] data_i;
    logic               valid_i, ready_i;
    logic               ready_o, sum_en_o, add_bias_o, clr_o, valid_o;
    logic signed [15:0] data_o;
    logic [2:0]         mem_addr_o;

    logic signed [15:0] d1_data_i;
    logic               d1_valid_i, d1_ready_i;
    logic               d1_ready_o, d1_sum_en_o, d1_add_bias_o, d1_clr_o, d1_valid_o;
    logic signed [15:0] d1_data_o;
    logic [0:0]         d1_mem_addr_o;

    fc_layer_sequencer #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .mem_addr_o(mem_addr_o),
        .sum_en_o(sum_en_o), .add_bias_o(add_bias_o), .neuron_clear_o(clr_o),
        .valid_o(valid_o), .ready_i(ready_i));

    fc_layer_sequencer #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .data_i(d1_data_i), .valid_i(d1_valid_i),
        .ready_o(d1_ready_o), .data_o(d1_data_o), .mem_addr_o(d1_mem_addr_o),
        .sum_en_o(d1_sum_en_o), .add_bias_o(d1_add_bias_o), .neuron_clear_o(d1_clr_o),
        .valid_o(d1_valid_o), .ready_i(d1_ready_i));

    // Behavioural neurons: registered ROM read, accumulate on sum_en.
    int rom4 [0:4];
    int rom1 [0:1];
    int mq4, nsum4, mq1, nsum1;

    always @(posedge clk) begin
        mq4 <= rom4[mem_addr_o];
        if (reset_i || clr_o) nsum4 <= 0;
        else if (sum_en_o) nsum4 <= nsum4 + (add_bias_o ? mq4 : int'(data_o) * mq4);
        mq1 <= rom1[d1_mem_addr_o];
        if (reset_i || d1_clr_o) nsum1 <= 0;
        else if (d1_sum_en_o) nsum1 <= nsum1 + (d1_add_bias_o ? mq1 : int'(d1_data_o) * mq1);
    end

    int checks = 0;
    int failures = 0;
    int c = 0;

    // Reference model: words taken, time of last word, time of release.
    int                 k, t_last, t_rel, acc, first_valid, vsum;
    bit                 hs_prev, chk_on;
    logic signed [15:0] data_e;

    typedef struct {
        logic signed [15:0] w [4];
        logic [3:0]         bub;
        int                 stall;
        int                 exp_sum;
        int                 exp_vrel;
    } vec_t;

    vec_t tab [4];

    task automatic chk1(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic signed [15:0] d, input bit r, input bit rst);
        bit rdy_e, vld_e, se_e, ab_e, cl_e, take;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        reset_i = rst;
        #1;
        if (chk_on) begin
            rdy_e = (k < H) && (c != t_rel + 1);
            vld_e = (k == H) && (c >= t_last + 3);
            se_e  = hs_prev || ((k == H) && (c == t_last + 2));
            ab_e  = (k == H) && (c == t_last + 2);
            cl_e  = (c == t_rel + 1);
            chk1("ready_o", int'(ready_o), int'(rdy_e));
            chk1("valid_o", int'(valid_o), int'(vld_e));
            chk1("sum_en_o", int'(sum_en_o), int'(se_e));
            chk1("add_bias_o", int'(add_bias_o), int'(ab_e));
            chk1("neuron_clear_o", int'(clr_o), int'(cl_e));
            chk1("mem_addr_o", int'(mem_addr_o), k);
            chk1("data_o", int'(data_o), int'(data_e));
            if (vld_e && (c == t_last + 3)) begin
                chk1("neuron_result", nsum4, acc + rom4[H]);
                first_valid = c;
                vsum        = nsum4;
            end
        end
        if (rst) begin
            k = 0; t_last = -100; t_rel = -100; acc = 0;
            hs_prev = 1'b0; data_e = '0; chk_on = 1'b1;
        end else begin
            take    = (k < H) && (c != t_rel + 1) && v;
            hs_prev = take;
            if (take) begin
                acc    = acc + int'(d) * rom4[k];
                data_e = d;
                k++;
                if (k == H) t_last = c;
            end else if ((k == H) && (c >= t_last + 3) && r) begin
                t_rel = c;
                k     = 0;
                acc   = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        c++;
    endtask

    task automatic run_vec(input int idx);
        int s, dn;
        bit vld, done_flag;
        s = c; dn = 0; done_flag = 1'b0; first_valid = -1; vsum = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, tab[idx].w[i], 1'b1, 1'b0);
            if (tab[idx].bub[i]) step(1'b0, 16'sh7777, 1'b1, 1'b0);
        end
        for (int n = 0; n < 30 && !done_flag; n++) begin
            vld = (k == H) && (c >= t_last + 3);
            if (c == t_rel + 1) done_flag = 1'b1;
            step(1'b1, 16'sh1234, !(vld && dn < tab[idx].stall), 1'b0);
            if (vld) dn++;
        end
        chk1("vector_completes", int'(done_flag), 1);
        chk1("valid_latency", first_valid - s, tab[idx].exp_vrel);
        chk1("vector_sum", vsum, tab[idx].exp_sum);
    endtask

    initial begin
        int x;
        chk_on = 1'b0;
        d1_valid_i = 1'b0; d1_ready_i = 1'b1; d1_data_i = '0;
        rom4 = '{1, 1, 1, 1, 5};
        rom1 = '{2, -4};
        tab[0] = '{w: '{16'sd1, 16'sd2, 16'sd3, 16'sd4}, bub: 4'b0000, stall: 0, exp_sum: 15, exp_vrel: 6};
        tab[1] = '{w: '{16'sd1, 16'sd2, 16'sd3, 16'sd4}, bub: 4'b0101, stall: 0, exp_sum: 15, exp_vrel: 8};
        tab[2] = '{w: '{16'sd1, 16'sd2, 16'sd3, 16'sd4}, bub: 4'b0000, stall: 5, exp_sum: 15, exp_vrel: 6};
        tab[3] = '{w: '{-16'sd1, -16'sd1, -16'sd1, -16'sd1}, bub: 4'b0000, stall: 0, exp_sum: 1, exp_vrel: 6};

        @(negedge clk);
        step(1'b0, 16'sd0, 1'b1, 1'b1);
        step(1'b0, 16'sd0, 1'b1, 1'b1);
        chk1("reset_ready", int'(ready_o), 1);
        chk1("reset_valid", int'(valid_o), 0);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Reset after two words aborts the vector.
        step(1'b1, 16'sd1, 1'b1, 1'b0);
        step(1'b1, 16'sd2, 1'b1, 1'b0);
        step(1'b0, 16'sd0, 1'b1, 1'b1);
        chk1("abort_data", int'(data_o), 0);
        chk1("abort_sum_en", int'(sum_en_o), 0);
        chk1("abort_addr", int'(mem_addr_o), 0);
        chk1("abort_ready", int'(ready_o), 1);
        chk1("abort_nsum", nsum4, 0);
        run_vec(0);

        // H=1: word 7, weight 2, bias -4.
        d1_valid_i = 1'b1; d1_data_i = 16'sd7;
        chk1("h1_ready", int'(d1_ready_o), 1);
        chk1("h1_addr0", int'(d1_mem_addr_o), 0);
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        d1_valid_i = 1'b0;
        chk1("h1_bias_addr", int'(d1_mem_addr_o), 1);
        chk1("h1_bias_ready", int'(d1_ready_o), 0);
        chk1("h1_sum_en_word", int'(d1_sum_en_o), 1);
        chk1("h1_data", int'(d1_data_o), 7);
        chk1("h1_no_bias_yet", int'(d1_add_bias_o), 0);
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        chk1("h1_flush_sum_en", int'(d1_sum_en_o), 1);
        chk1("h1_flush_bias", int'(d1_add_bias_o), 1);
        chk1("h1_flush_valid", int'(d1_valid_o), 0);
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        chk1("h1_valid", int'(d1_valid_o), 1);
        chk1("h1_result", nsum1, 10);
        chk1("h1_done_sum_en", int'(d1_sum_en_o), 0);
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        chk1("h1_clear", int'(d1_clr_o), 1);
        chk1("h1_clear_valid", int'(d1_valid_o), 0);
        chk1("h1_clear_ready", int'(d1_ready_o), 0);
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        chk1("h1_clear_end", int'(d1_clr_o), 0);
        chk1("h1_ready_again", int'(d1_ready_o), 1);
        chk1("h1_addr_again", int'(d1_mem_addr_o), 0);

        // Random traffic against the model.
        for (int i = 0; i < 5; i++) rom4[i] = int'($urandom_range(20)) - 10;
        for (int n = 0; n < 400; n++) begin
            x = int'($urandom_range(200)) - 100;
            step($urandom_range(9) < 7, 16'(x), 1'($urandom_range(1)),
                 $urandom_range(99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
